// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between the CPU pipeline, the HI/LO controller
// and the external multiply/divide engine.
interface muldiv_ctrl_if;
    logic        op_start;
    logic        op_div;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic        rd_lo;
    logic        md_HDControl;
    logic [31:0] md_A;
    logic [31:0] md_B;
    logic        md_reset;
    logic [31:0] md_HI;
    logic [31:0] md_LO;
    logic        md_Done;
    logic        md_DivBy0;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;
    logic        stall;
    logic        done;
    logic        err;
    logic        div0_exc;

    modport slave (
        input  op_start, op_div, rs_val, rt_val, rd_hi, rd_lo,
        input  md_HI, md_LO, md_Done, md_DivBy0,
        output md_HDControl, md_A, md_B, md_reset,
        output hi_q, lo_q, busy, stall, done, err, div0_exc
    );

    modport master (
        output op_start, op_div, rs_val, rt_val, rd_hi, rd_lo,
        output md_HI, md_LO, md_Done, md_DivBy0,
        input  md_HDControl, md_A, md_B, md_reset,
        input  hi_q, lo_q, busy, stall, done, err, div0_exc
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences an external mul/div engine and owns HI/LO.
// Option MULDIV_DIV0_TRAP_EN: trap divide-by-zero without running the engine.
module muldiv_ctrl #(
    parameter int TIMEOUT = 48
) (
    input logic          clock,
    input logic          reset,
    muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, CAPT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] run_cnt;
    logic          op_div_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic          err_r;
    logic          accept;
    logic          timeout;
    logic          capture;
    logic          unused_div0;
`ifdef MULDIV_DIV0_TRAP_EN
    logic          trap;
    logic          trap_q;
`endif

    // Next-state and per-cycle strobes of the operation sequencer
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
        trap      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.op_start) begin
                    accept    = 1'b1;
                    state_nxt = CLR;
`ifdef MULDIV_DIV0_TRAP_EN
                    if (bus.op_div && bus.rt_val == 32'd0) begin
                        trap      = 1'b1;
                        state_nxt = CAPT;
                    end
`endif
                end
            end
            CLR: state_nxt = RUN;
            RUN: begin
                if (bus.md_Done) begin
                    state_nxt = CAPT;
                end else if (run_cnt == CW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CAPT: begin
                state_nxt = IDLE;
`ifdef MULDIV_DIV0_TRAP_EN
                capture   = !trap_q;
`else
                capture   = 1'b1;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand holding registers, loaded once per accepted request
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (accept) begin
            op_div_q <= bus.op_div;
            a_q      <= bus.rs_val;
            b_q      <= bus.rt_val;
        end
    end

`ifdef MULDIV_DIV0_TRAP_EN
    // Remembers that the current CAPT cycle is a trap, not a capture
    always_ff @(posedge clock) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else if (accept) begin
            trap_q <= trap;
        end
    end
`endif

    // RUN cycle counter; zero whenever the engine is not running
    always_ff @(posedge clock) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + CW'(1);
        end else begin
            run_cnt <= '0;
        end
    end

    // Architectural HI/LO, written only by a completed operation
    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (capture) begin
            hi_r <= bus.md_HI;
            lo_r <= bus.md_LO;
        end
    end

    // Timeout pulse lands in the IDLE cycle after the abort
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= timeout;
        end
    end

    // Engine is only released from reset while running
    assign bus.md_reset     = !reset || (state != RUN);
    assign bus.md_A         = reset ? a_q : '0;
    assign bus.md_B         = reset ? b_q : '0;
    assign bus.md_HDControl = reset & op_div_q;

    assign bus.hi_q  = hi_r;
    assign bus.lo_q  = lo_r;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = (bus.rd_hi | bus.rd_lo) & bus.busy;
    assign bus.done  = capture;
    assign bus.err   = err_r;
`ifdef MULDIV_DIV0_TRAP_EN
    assign bus.div0_exc = (state == CAPT) && trap_q;
`else
    assign bus.div0_exc = 1'b0;
`endif

    // Engine's own divide-by-zero flag carries no extra information here
    assign unused_div0 = bus.md_DivBy0;
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 48: maximum RUN cycles allowed before abort.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port op_start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op_div  input  1  0 = multiply, 1 = divide; sampled with op_start.
REQ-006 SHALL have ports rs_val and rt_val  input  32 each  operands A and B; sampled with op_start.
REQ-007 SHALL have ports rd_hi and rd_lo  input  1 each  MFHI and MFLO read requests.
REQ-008 SHALL have ports md_HDControl  output  1, md_A  output  32 and md_B  output  32  engine opcode and operands.
REQ-009 SHALL have port md_reset  output  1  engine reset, active-high.
REQ-010 SHALL have ports md_HI and md_LO  input  32 each, and md_Done and md_DivBy0  input  1 each  engine results and status.
REQ-011 SHALL have ports hi_q and lo_q  output  32 each  architectural HI and LO registers.
REQ-012 SHALL have ports busy, stall, done and err  output  1 each.
REQ-013 SHALL have port div0_exc  output  1  divide-by-zero exception pulse.

Function
REQ-014 SHALL implement FSM states IDLE, CLR, RUN and CAPT.
REQ-015 IDLE with op_start=1: latch op_div, rs_val and rt_val into holding registers, then go to CLR.
REQ-016 IDLE with op_start=0: remain in IDLE.
REQ-017 CLR: assert md_reset=1 for exactly one cycle, then go to RUN.
REQ-018 RUN: md_reset=0; md_A, md_B and md_HDControl driven from holding registers and held stable until CAPT completes.
REQ-019 RUN with md_Done=1: go to CAPT.
REQ-020 CAPT: write hi_q<=md_HI and lo_q<=md_LO; pulse done=1 for one cycle; assert md_reset=1; next state IDLE.
REQ-021 A full operation SHALL take 1 (CLR) + N (RUN, until md_Done) + 1 (CAPT) cycles, measured from the op_start acceptance edge.
REQ-022 busy=1 in CLR, RUN and CAPT; busy=0 in IDLE.
REQ-023 op_start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 stall=(rd_hi|rd_lo)&busy, combinational.
REQ-025 A read in the CAPT cycle SHALL stall; the read in the following IDLE cycle SHALL return the new values.
REQ-026 A per-operation RUN cycle counter SHALL start at 0 on entry to RUN.
REQ-027 When the RUN counter reaches TIMEOUT without md_Done: pulse err=1 for one cycle, leave hi_q and lo_q unchanged, assert md_reset for one cycle, and go to IDLE.
REQ-028 In IDLE, md_reset=1, so the engine is held cleared between operations.
REQ-029 done, err and div0_exc SHALL be mutually exclusive single-cycle pulses.

Reset
REQ-030 reset=0 at a clock edge SHALL force state IDLE and clear the RUN counter and holding registers.
REQ-031 reset=0 at a clock edge SHALL set hi_q=0, lo_q=0, busy=0, done=0, err=0 and div0_exc=0.
REQ-032 While reset=0: md_reset=1, md_A=0, md_B=0 and md_HDControl=0.
REQ-033 Reset mid-operation SHALL abort without a done pulse; hi_q and lo_q SHALL read 0.

Configuration
REQ-034 Macro MULDIV_DIV0_TRAP_EN defined: divide with rt_val==0 accepted in IDLE SHALL skip CLR and RUN.
REQ-035 In that trap case: pulse div0_exc=1 one cycle later, leave hi_q and lo_q unchanged, return to IDLE; busy=1 for that one cycle.
REQ-036 MULDIV_DIV0_TRAP_EN undefined: divide-by-zero SHALL run through the engine like any divide, capture md_HI and md_LO in CAPT, and pulse done.
REQ-037 MULDIV_DIV0_TRAP_EN undefined: div0_exc SHALL be tied to 0 and md_DivBy0 ignored.

Verification
REQ-038 Multiply, rs=7 and rt=0xFFFFFFFD (-3) -> one done pulse; hi_q=0xFFFFFFFF and lo_q=0xFFFFFFEB; busy high from acceptance until after CAPT.
REQ-039 Divide, rs=100 and rt=7 -> done pulse; lo_q=14 and hi_q=2; rd_lo raised during RUN gives stall=1 until IDLE.
REQ-040 Divide, rs=5 and rt=0 with MULDIV_DIV0_TRAP_EN defined -> div0_exc pulse two edges after op_start; hi_q and lo_q keep prior values; engine never leaves reset.
REQ-041 Divide, rs=5 and rt=0 with MULDIV_DIV0_TRAP_EN undefined -> done pulse; hi_q and lo_q equal engine outputs; div0_exc stays 0.
REQ-042 Engine stub holding md_Done=0 -> err pulse after exactly 48 RUN cycles; hi_q and lo_q unchanged; next op_start accepted.
REQ-043 reset=0 for one cycle at RUN cycle 10 of a multiply -> IDLE, hi_q=0, lo_q=0, no done pulse.
REQ-044 Second op_start issued while busy -> ignored; exactly one done pulse.
